regfile_seq: RTL and testbench

//   Multi-cycle command sequencer that owns the write port and both read-select

---
 rtl/regfile_seq.sv | 168 ++++++++++++++++
 tb/tb_regfile_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq.sv
// regfile_seq
// Multi-cycle command sequencer in front of an 8x16 register file.
// It accepts one command at a time over a valid/ready handshake. For a
// register command it reads the operands, computes an ALU result and
// writes that result back. A bulk-clear command zeroes every register,
// one register per cycle. The register file itself lives outside this
// block: the block drives the write port and both read selects, and
// takes back the two combinational read ports.
module regfile_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dr,
    input  logic [ADDR_W-1:0] cmd_sr1,
    input  logic [ADDR_W-1:0] cmd_sr2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dr,
    output logic [ADDR_W-1:0] rf_sr1,
    output logic [ADDR_W-1:0] rf_sr2,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rb
);

    // Opcode encoding used by the decode logic.
    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    // Index of the last register. The clear sweep ends on this register.
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t             state_reg;
    logic [2:0]         op_reg;
    logic [ADDR_W-1:0]  dr_reg;
    logic [DATA_W-1:0]  imm_reg;
    logic [DATA_W-1:0]  a_reg;
    logic [DATA_W-1:0]  b_reg;
    logic [ADDR_W-1:0]  clr_cnt_reg;
    logic [DATA_W-1:0]  alu_next;

    // The block can take a command only while it is idle.
    assign cmd_ready = (state_reg == IDLE);

    // ALU over the operands captured in READ. Arithmetic wraps modulo 2**DATA_W.
    always_comb begin
        alu_next = '0;
        case (op_reg)
            OP_MOV:  alu_next = a_reg;
            OP_ADD:  alu_next = a_reg + b_reg;
            OP_SUB:  alu_next = a_reg - b_reg;
            OP_AND:  alu_next = a_reg & b_reg;
            OP_NOT:  alu_next = ~a_reg;
            OP_LDI:  alu_next = imm_reg;
            default: alu_next = '0;
        endcase
    end

    // Sequencer FSM. All register-file controls and status outputs are registered here.
    // Reset abandons any command in flight. It drops rf_we at once, so a partial
    // write cannot land after reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_reg      <= OP_NOP;
            dr_reg      <= '0;
            imm_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            clr_cnt_reg <= '0;
            done        <= 1'b0;
            result      <= '0;
            rf_we       <= 1'b0;
            rf_dr       <= '0;
            rf_sr1      <= '0;
            rf_sr2      <= '0;
            rf_din      <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg  <= cmd_op;
                        dr_reg  <= cmd_dr;
                        imm_reg <= cmd_imm;
                        if (cmd_op == OP_CLR) begin
                            // The first clear write goes out in the very next cycle.
                            state_reg   <= CLEAR;
                            clr_cnt_reg <= '0;
                            rf_we       <= 1'b1;
                            rf_dr       <= '0;
                            rf_din      <= '0;
                        end else begin
                            state_reg <= READ;
                            rf_sr1    <= cmd_sr1;
                            rf_sr2    <= cmd_sr2;
                        end
                    end
                end
                READ: begin
                    // Capture the operands now. A later write to the same register
                    // then cannot affect this command.
                    a_reg     <= rf_ra;
                    b_reg     <= rf_rb;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    if (op_reg == OP_NOP) begin
                        state_reg <= IDLE;
                        done      <= 1'b1;
                    end else begin
                        result    <= alu_next;
                        rf_we     <= 1'b1;
                        rf_dr     <= dr_reg;
                        rf_din    <= alu_next;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    rf_we     <= 1'b0;
                    rf_dr     <= '0;
                    rf_din    <= '0;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                CLEAR: begin
                    if (clr_cnt_reg == CLR_LAST) begin
                        clr_cnt_reg <= '0;
                        rf_we       <= 1'b0;
                        rf_dr       <= '0;
                        done        <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                        rf_dr       <= clr_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rf_we     <= 1'b0;
                    rf_din    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq
// Directed bench for regfile_seq. The bench holds its own 8x16 register
// file, with a write on the rising edge and combinational reads. All
// expected values are hand-computed constants.
module tb_regfile_seq;

    localparam int DW = 16;
    localparam int AW = 3;

    localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3;
    localparam logic [2:0] NOT_ = 3'd4, LDI = 3'd5, CLR = 3'd6, NOP = 3'd7;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_dr, cmd_sr1, cmd_sr2;
    logic [DW-1:0] cmd_imm;
    logic          done;
    logic [DW-1:0] result;
    logic          rf_we;
    logic [AW-1:0] rf_dr, rf_sr1, rf_sr2;
    logic [DW-1:0] rf_din, rf_ra, rf_rb;

    logic [DW-1:0] mem [0:7];

    int checks = 0;
    int errors = 0;

    regfile_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dr    (cmd_dr),
        .cmd_sr1   (cmd_sr1),
        .cmd_sr2   (cmd_sr2),
        .cmd_imm   (cmd_imm),
        .done      (done),
        .result    (result),
        .rf_we     (rf_we),
        .rf_dr     (rf_dr),
        .rf_sr1    (rf_sr1),
        .rf_sr2    (rf_sr2),
        .rf_din    (rf_din),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb)
    );

    always #5 clk = ~clk;

    // External register file that the sequencer drives
    always @(posedge clk) begin
        if (rf_we) mem[rf_dr] <= rf_din;
    end
    assign rf_ra = mem[rf_sr1];
    assign rf_rb = mem[rf_sr2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issue one command. Count cycles from the accept edge until done appears,
    // counting writes and watching the bus rules along the way.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [AW-1:0] dr,
                           input logic [AW-1:0] sr1, input logic [AW-1:0] sr2,
                           input logic [DW-1:0] imm, input int exp_lat, input int exp_writes);
        int wait_n, lat, writes, bad;
        @(negedge clk);
        cmd_op = op; cmd_dr = dr; cmd_sr1 = sr1; cmd_sr2 = sr2; cmd_imm = imm;
        cmd_valid = 1'b1;
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, " ready"}, cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; writes = 0; bad = 0;
        while (!done && lat < 20) begin
            if (cmd_ready) bad++;
            if (!rf_we && rf_din != 0) bad++;
            if (rf_we) begin
                if (op == CLR && rf_dr != writes[AW-1:0]) bad++;
                if (op != CLR && rf_dr != dr) bad++;
                writes++;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " writes"}, writes, exp_writes);
        check({tag, " busy bus rules"}, bad, 0);
        check({tag, " ready at done"}, cmd_ready, 1);
        check({tag, " rf_we at done"}, rf_we, 0);
        @(negedge clk);
        check({tag, " done single pulse"}, done, 0);
    endtask

    task automatic load_all();
        for (int i = 0; i < 8; i++)
            run_cmd($sformatf("LDI R%0d", i), LDI, AW'(i), '0, '0, DW'(16'h1000 + i), 4, 1);
    endtask

    initial begin
        int acc [0:2];
        int idx, c, low_cnt, wait_n, bad;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_dr = '0; cmd_sr1 = '0; cmd_sr2 = '0; cmd_imm = '0;
        repeat (2) @(negedge clk);
        check("reset cmd_ready", cmd_ready, 1);
        check("reset done", done, 0);
        check("reset rf_we", rf_we, 0);
        check("reset result", result, 0);
        check("reset rf_din", rf_din, 0);
        reset = 1'b0;

        // 1: LDI, LDI, ADD
        run_cmd("LDI R1", LDI, 3'd1, 3'd0, 3'd0, 16'h1234, 4, 1);
        check("R1", mem[1], 16'h1234);
        run_cmd("LDI R2", LDI, 3'd2, 3'd0, 3'd0, 16'h0FFF, 4, 1);
        check("R2", mem[2], 16'h0FFF);
        run_cmd("ADD R3", ADD, 3'd3, 3'd1, 3'd2, 16'h0, 4, 1);
        check("R3 sum", mem[3], 16'h2233);
        check("result sum", result, 16'h2233);

        // Unary operations
        run_cmd("MOV R2", MOV, 3'd2, 3'd3, 3'd0, 16'h0, 4, 1);
        check("R2 mov", mem[2], 16'h2233);
        run_cmd("NOT R6", NOT_, 3'd6, 3'd3, 3'd0, 16'h0, 4, 1);
        check("R6 not", mem[6], 16'hDDCC);

        // 2: Wraparound and borrow, including a self-update
        run_cmd("LDI R1", LDI, 3'd1, 3'd0, 3'd0, 16'h0001, 4, 1);
        run_cmd("LDI R4", LDI, 3'd4, 3'd0, 3'd0, 16'hFFFF, 4, 1);
        run_cmd("ADD R4", ADD, 3'd4, 3'd4, 3'd1, 16'h0, 4, 1);
        check("R4 wrap", mem[4], 16'h0000);
        run_cmd("LDI R1", LDI, 3'd1, 3'd0, 3'd0, 16'h0000, 4, 1);
        run_cmd("LDI R2", LDI, 3'd2, 3'd0, 3'd0, 16'h0001, 4, 1);
        run_cmd("SUB R5", SUB, 3'd5, 3'd1, 3'd2, 16'h0, 4, 1);
        check("R5 borrow", mem[5], 16'hFFFF);

        // 6: NOP does not write, and result holds
        run_cmd("NOP", NOP, 3'd5, 3'd1, 3'd2, 16'h0, 3, 0);
        check("NOP result held", result, 16'hFFFF);
        check("NOP R5 kept", mem[5], 16'hFFFF);

        // 3: Back-to-back commands with cmd_valid held high
        @(negedge clk);
        cmd_op = LDI; cmd_dr = 3'd6; cmd_imm = 16'hAAAA; cmd_sr1 = '0; cmd_sr2 = '0;
        cmd_valid = 1'b1;
        idx = 0; c = 0; low_cnt = 0;
        while (idx < 3 && c < 60) begin
            if (cmd_ready) begin
                acc[idx] = c;
                idx++;
                @(posedge clk);
                @(negedge clk);
                c++;
                if (idx == 1) begin
                    cmd_op = LDI; cmd_dr = 3'd7; cmd_imm = 16'h0FF0;
                end else if (idx == 2) begin
                    cmd_op = AND_; cmd_dr = 3'd0; cmd_sr1 = 3'd6; cmd_sr2 = 3'd7; cmd_imm = '0;
                end else begin
                    cmd_valid = 1'b0;
                end
            end else begin
                low_cnt++;
                @(negedge clk);
                c++;
            end
        end
        check("b2b accepts", idx, 3);
        check("b2b gap 1", acc[1] - acc[0], 4);
        check("b2b gap 2", acc[2] - acc[1], 4);
        check("b2b ready low cycles", low_cnt, 6);
        wait_n = 0;
        while (!done && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("b2b final done", done, 1);
        check("R0 and", mem[0], 16'h0AA0);
        check("result and", result, 16'h0AA0);

        // 4: Bulk clear
        load_all();
        check("R7 loaded", mem[7], 16'h1007);
        run_cmd("CLR", CLR, 3'd0, 3'd0, 3'd0, 16'h0, 9, 8);
        bad = 0;
        for (int i = 0; i < 8; i++) if (mem[i] != 16'h0) bad++;
        check("CLR nonzero regs", bad, 0);

        // 5: Reset during a clear, asserted while clr_cnt is 3
        load_all();
        @(negedge clk);
        cmd_op = CLR; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_n = 0;
        while (!(rf_we && rf_dr == 3'd3) && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("CLR reached R3", rf_dr, 3);
        reset = 1'b1;
        #1;
        check("reset drops rf_we", rf_we, 0);
        check("reset ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (done || rf_we) bad++;
            @(negedge clk);
        end
        check("no done after abort", bad, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) if (mem[i] != 16'h0) bad++;
        check("R0-R2 cleared", bad, 0);
        bad = 0;
        for (int i = 3; i < 8; i++) if (mem[i] != DW'(16'h1000 + i)) bad++;
        check("R3-R7 kept", bad, 0);
        check("R3 value", mem[3], 16'h1003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
